// File: rtl/ram_burst_reader_if.sv
// ram_burst_reader_if: bundles the command, RAM-port and output-stream signals
// of the burst reader.
//   cmd_valid/cmd_ready/cmd_addr/cmd_len : burst request handshake
//   ram_en/ram_we/ram_addr/ram_di/ram_do : reader-side RAM port
//   out_valid/out_ready/out_data/out_last: output word stream
//   busy/done                            : burst status
// slave  = the burst reader itself; master = the surrounding system.
interface ram_burst_reader_if #(
    parameter int unsigned WIDTH_G   = 32,
    parameter int unsigned ADDRWIDTH = 6,
    parameter int unsigned LEN_WIDTH = 7
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ADDRWIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0] cmd_len;
    logic                 ram_en;
    logic                 ram_we;
    logic [ADDRWIDTH-1:0] ram_addr;
    logic [WIDTH_G-1:0]   ram_di;
    logic [WIDTH_G-1:0]   ram_do;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH_G-1:0]   out_data;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, ram_do, out_ready,
        input  cmd_ready, ram_en, ram_we, ram_addr, ram_di,
               out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, ram_do, out_ready,
        output cmd_ready, ram_en, ram_we, ram_addr, ram_di,
               out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: reads cmd_len sequential words from a block RAM with
// 1-cycle registered read latency, starting at cmd_addr (wrapping), and
// streams them out on a valid/ready port with a last-beat marker.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ram_burst_reader_if.slave (command, RAM port, output stream,
//                busy/done status)
module ram_burst_reader #(
    parameter int unsigned WIDTH_G    = 32,
    parameter int unsigned ADDRWIDTH  = 6,
    parameter int unsigned LEN_WIDTH  = 7,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    ram_burst_reader_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} stateE;

    stateE                state;
    logic [ADDRWIDTH-1:0] addrQ;
    logic [LEN_WIDTH-1:0] issueCnt;
    logic [LEN_WIDTH-1:0] pushRem;
    logic                 zeroLen;
    logic [CNT_W-1:0]     outstanding;
    logic                 rdPend;

    logic [WIDTH_G-1:0]   memData [FIFO_DEPTH];
    logic                 memLast [FIFO_DEPTH];
    logic [PTR_W-1:0]     wrPtr;
    logic [PTR_W-1:0]     rdPtr;
    logic [CNT_W-1:0]     fifoCount;

    logic                 cmdReady;
    logic                 ramEn;
    logic [ADDRWIDTH-1:0] ramAddr;
    logic                 outValid;
    logic [WIDTH_G-1:0]   outData;
    logic                 outLast;
    logic                 busyQ;
    logic                 doneQ;

    logic                 accept;
    logic                 issue;
    logic                 push;
    logic                 pop;
    logic                 pushLast;
    logic [CNT_W-1:0]     countAfterPop;
    logic [CNT_W-1:0]     countNext;
    logic [PTR_W-1:0]     rdPtrNext;

    // Handshakes and credit check: buffered plus in-flight words never exceed the FIFO.
    assign accept        = bus.cmd_valid && cmdReady;
    assign issue         = (state == RUN) && (issueCnt != '0) &&
                           (({1'b0, fifoCount} + {1'b0, outstanding}) < (CNT_W + 1)'(FIFO_DEPTH));
    assign push          = rdPend;
    assign pop           = outValid && bus.out_ready;
    assign pushLast      = (pushRem == LEN_WIDTH'(1));
    assign countAfterPop = fifoCount - CNT_W'(pop);
    assign countNext     = countAfterPop + CNT_W'(push);
    assign rdPtrNext     = rdPtr + PTR_W'(pop);

    // FIFO storage; entries are only consumed through the registered head below.
    always_ff @(posedge clk) begin
        if (push) begin
            memData[wrPtr] <= bus.ram_do;
            memLast[wrPtr] <= pushLast;
        end
    end

    // Control FSM, read issue, capture pipeline and registered FIFO head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addrQ       <= '0;
            issueCnt    <= '0;
            pushRem     <= '0;
            zeroLen     <= 1'b0;
            outstanding <= '0;
            rdPend      <= 1'b0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            fifoCount   <= '0;
            cmdReady    <= 1'b1;
            ramEn       <= 1'b0;
            ramAddr     <= '0;
            outValid    <= 1'b0;
            outData     <= '0;
            outLast     <= 1'b0;
            busyQ       <= 1'b0;
            doneQ       <= 1'b0;
        end else begin
            ramEn  <= 1'b0;
            doneQ  <= 1'b0;
            // The RAM registers data one edge after ram_en; capture one edge later.
            rdPend <= ramEn;

            if (issue) begin
                ramEn    <= 1'b1;
                ramAddr  <= addrQ;
                addrQ    <= addrQ + ADDRWIDTH'(1);
                issueCnt <= issueCnt - LEN_WIDTH'(1);
            end
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(push);

            if (push) begin
                wrPtr   <= wrPtr + PTR_W'(1);
                pushRem <= pushRem - LEN_WIDTH'(1);
            end
            rdPtr     <= rdPtrNext;
            fifoCount <= countNext;
            outValid  <= (countNext != '0);

            // Head register: bypass the incoming word when it lands in an empty FIFO.
            if (push && (countAfterPop == '0)) begin
                outData <= bus.ram_do;
                outLast <= pushLast;
            end else if (countAfterPop != '0) begin
                outData <= memData[rdPtrNext];
                outLast <= memLast[rdPtrNext];
            end else begin
                outData <= '0;
                outLast <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        addrQ    <= bus.cmd_addr;
                        issueCnt <= bus.cmd_len;
                        pushRem  <= bus.cmd_len;
                        busyQ    <= 1'b1;
                        cmdReady <= 1'b0;
                        if (bus.cmd_len == '0) begin
                            zeroLen <= 1'b1;
                            state   <= DRAIN;
                        end else begin
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue && (issueCnt == LEN_WIDTH'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (zeroLen || (pop && outLast)) begin
                        state    <= IDLE;
                        zeroLen  <= 1'b0;
                        busyQ    <= 1'b0;
                        cmdReady <= 1'b1;
                        doneQ    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmdReady;
    assign bus.ram_en    = ramEn;
    assign bus.ram_we    = 1'b0;
    assign bus.ram_addr  = ramAddr;
    assign bus.ram_di    = '0;
    assign bus.out_valid = outValid;
    assign bus.out_data  = outData;
    assign bus.out_last  = outLast;
    assign bus.busy      = busyQ;
    assign bus.done      = doneQ;
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: directed bench for ram_burst_reader with a RAM model,
// a queue-based burst model checked every cycle, and literal spot checks.
module tb_ram_burst_reader;
    localparam int unsigned WIDTH_G    = 32;
    localparam int unsigned ADDRWIDTH  = 6;
    localparam int unsigned LEN_WIDTH  = 7;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned RAM_WORDS  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_burst_reader_if #(.WIDTH_G(WIDTH_G), .ADDRWIDTH(ADDRWIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

    ram_burst_reader #(
        .WIDTH_G(WIDTH_G), .ADDRWIDTH(ADDRWIDTH), .LEN_WIDTH(LEN_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Block RAM read port: registered output, one cycle after en.
    logic [WIDTH_G-1:0] ramMem [RAM_WORDS];
    always @(posedge clk) begin
        if (bus.ram_en) bus.ram_do <= ramMem[bus.ram_addr];
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Burst model: each accepted command expands into its list of words and addresses.
    typedef struct packed {
        logic [WIDTH_G-1:0] d;
        logic               l;
    } expT;

    expT                  expQ[$];
    logic [ADDRWIDTH-1:0] expAddr[$];
    bit                   inBurst = 1'b0;
    bit                   expDone = 1'b0;
    bit                   zeroStage = 1'b0;
    bit                   holdPrev = 1'b0;
    logic [WIDTH_G-1:0]   holdData;
    logic                 holdLast;
    int                   beatsSeen = 0;
    int                   lastsSeen = 0;
    int                   donesSeen = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            expAddr.delete();
            inBurst   = 1'b0;
            expDone   = 1'b0;
            zeroStage = 1'b0;
            holdPrev  = 1'b0;
        end else begin
            expT                  e;
            bit                   lastHs;
            bit                   acc;
            logic [ADDRWIDTH-1:0] a;
            lastHs = 1'b0;
            chk("done", 64'(bus.done), 64'(expDone));
            chk("busy", 64'(bus.busy), 64'(inBurst));
            chk("cmd_ready", 64'(bus.cmd_ready), 64'(!inBurst));
            chk("ram_we_di", 64'({bus.ram_we, |bus.ram_di}), 64'(0));
            chk("fifo_bound", 64'(dut.fifoCount <= FIFO_DEPTH), 64'(1));
            if (bus.ram_en) begin
                if (expAddr.size() == 0) chk("ram_en_spurious", 64'(1), 64'(0));
                else chk("ram_addr", 64'(bus.ram_addr), 64'(expAddr.pop_front()));
            end
            if (holdPrev) begin
                chk("hold_valid", 64'(bus.out_valid), 64'(1));
                chk("hold_data", 64'(bus.out_data), 64'(holdData));
                chk("hold_last", 64'(bus.out_last), 64'(holdLast));
            end
            if (bus.out_valid && bus.out_ready) begin
                beatsSeen++;
                if (bus.out_last) lastsSeen++;
                if (expQ.size() == 0) begin
                    chk("beat_extra", 64'(1), 64'(0));
                end else begin
                    e = expQ.pop_front();
                    chk("out_data", 64'(bus.out_data), 64'(e.d));
                    chk("out_last", 64'(bus.out_last), 64'(e.l));
                    lastHs = e.l;
                end
            end
            if (bus.done) donesSeen++;
            holdPrev = bus.out_valid && !bus.out_ready;
            holdData = bus.out_data;
            holdLast = bus.out_last;
            acc = bus.cmd_valid && bus.cmd_ready;
            if (acc) begin
                for (int i = 0; i < int'(bus.cmd_len); i++) begin
                    a = bus.cmd_addr + ADDRWIDTH'(i);
                    expQ.push_back('{d: ramMem[a], l: (i == int'(bus.cmd_len) - 1)});
                    expAddr.push_back(a);
                end
            end
            expDone   = lastHs || zeroStage;
            inBurst   = acc ? 1'b1 : ((lastHs || zeroStage) ? 1'b0 : inBurst);
            zeroStage = acc && (bus.cmd_len == '0);
        end
    end

    // Stimulus helpers run in the phase just after a rising edge.
    task automatic issueCmd(input logic [ADDRWIDTH-1:0] a, input logic [LEN_WIDTH-1:0] l);
        int n = 0;
        while (!bus.cmd_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_ready_wait", 64'(bus.cmd_ready), 64'(1));
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        int d0 = donesSeen;
        while (donesSeen == d0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_wait", 64'(donesSeen - d0), 64'(1));
    endtask

    task automatic checkResetOuts(input string tag);
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
        chk({tag, "_ram_en"},    64'(bus.ram_en),    64'(0));
        chk({tag, "_ram_addr"},  64'(bus.ram_addr),  64'(0));
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        chk({tag, "_out_data"},  64'(bus.out_data),  64'(0));
        chk({tag, "_out_last"},  64'(bus.out_last),  64'(0));
        chk({tag, "_busy"},      64'(bus.busy),      64'(0));
        chk({tag, "_done"},      64'(bus.done),      64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d0;
        int b0;
        int l0;
        int ens;
        int n;
        for (int i = 0; i < int'(RAM_WORDS); i++) ramMem[i] = WIDTH_G'(i + 100);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetOuts("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic burst: 105..108, 3-cycle first-word latency, last on 108.
        d0 = donesSeen;
        issueCmd(6'd5, 7'd4);
        @(negedge clk); chk("t1_n0_valid", 64'(bus.out_valid), 64'(0));
        @(negedge clk); chk("t1_n1_ram_en", 64'(bus.ram_en), 64'(1));
                        chk("t1_n1_ram_addr", 64'(bus.ram_addr), 64'(5));
        @(negedge clk); chk("t1_n2_valid", 64'(bus.out_valid), 64'(0));
        @(negedge clk); chk("t1_n3_valid", 64'(bus.out_valid), 64'(1));
                        chk("t1_n3_data", 64'(bus.out_data), 64'(105));
        @(negedge clk); chk("t1_n4_data", 64'(bus.out_data), 64'(106));
        @(negedge clk); chk("t1_n5_last", 64'(bus.out_last), 64'(0));
        @(negedge clk); chk("t1_n6_data", 64'(bus.out_data), 64'(108));
                        chk("t1_n6_last", 64'(bus.out_last), 64'(1));
        @(negedge clk); chk("t1_n7_done", 64'(bus.done), 64'(1));
                        chk("t1_n7_busy", 64'(bus.busy), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("t1_done_once", 64'(donesSeen - d0), 64'(1));

        // Address wrap: 62,63,0,1.
        issueCmd(6'd62, 7'd4);
        repeat (4) @(negedge clk);
        chk("t2_n3_data", 64'(bus.out_data), 64'(162));
        repeat (2) @(negedge clk);
        chk("t2_n5_data", 64'(bus.out_data), 64'(100));
        @(negedge clk);
        chk("t2_n6_data", 64'(bus.out_data), 64'(101));
        chk("t2_n6_last", 64'(bus.out_last), 64'(1));
        @(posedge clk); #1;
        waitDone(20);

        // Backpressure: only FIFO_DEPTH reads in flight, head held at 105.
        bus.out_ready = 1'b0;
        b0 = beatsSeen;
        issueCmd(6'd5, 7'd8);
        ens = 0;
        repeat (10) begin
            @(negedge clk);
            ens += int'(bus.ram_en);
        end
        chk("t3_reads_held", 64'(ens), 64'(4));
        chk("t3_ram_en_stop", 64'(bus.ram_en), 64'(0));
        chk("t3_head_valid", 64'(bus.out_valid), 64'(1));
        chk("t3_head_data", 64'(bus.out_data), 64'(105));
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        waitDone(60);
        chk("t3_beats", 64'(beatsSeen - b0), 64'(8));

        // Long burst with random backpressure and double wrap.
        d0 = donesSeen;
        b0 = beatsSeen;
        l0 = lastsSeen;
        issueCmd(6'd10, 7'd127);
        n = 0;
        while (donesSeen == d0 && n < 3000) begin
            @(posedge clk); #1;
            bus.out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t4_beats", 64'(beatsSeen - b0), 64'(127));
        chk("t4_lasts", 64'(lastsSeen - l0), 64'(1));
        chk("t4_dones", 64'(donesSeen - d0), 64'(1));
        chk("t4_model_empty", 64'(expQ.size()), 64'(0));

        // Zero-length command: done one cycle after accept, no reads, no beats.
        issueCmd(6'd7, 7'd0);
        @(negedge clk); chk("t5_n0_done", 64'(bus.done), 64'(0));
                        chk("t5_n0_busy", 64'(bus.busy), 64'(1));
                        chk("t5_n0_ram_en", 64'(bus.ram_en), 64'(0));
        @(negedge clk); chk("t5_n1_done", 64'(bus.done), 64'(1));
                        chk("t5_n1_cmd_ready", 64'(bus.cmd_ready), 64'(1));
                        chk("t5_n1_valid", 64'(bus.out_valid), 64'(0));
        @(negedge clk); chk("t5_n2_done", 64'(bus.done), 64'(0));
        @(posedge clk); #1;

        // Reset mid-burst after 3 beats, then a fresh burst.
        b0 = beatsSeen;
        issueCmd(6'd20, 7'd8);
        n = 0;
        while (beatsSeen < b0 + 3 && n < 40) begin
            @(negedge clk); #2;
            n++;
        end
        chk("t6_three_beats", 64'(beatsSeen - b0), 64'(3));
        rst_n = 1'b0;
        #1;
        checkResetOuts("t6_abort");
        d0 = donesSeen;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t6_no_done", 64'(donesSeen - d0), 64'(0));
        issueCmd(6'd0, 7'd2);
        repeat (4) @(negedge clk);
        chk("t6_n3_data", 64'(bus.out_data), 64'(100));
        @(negedge clk);
        chk("t6_n4_data", 64'(bus.out_data), 64'(101));
        chk("t6_n4_last", 64'(bus.out_last), 64'(1));
        @(posedge clk); #1;
        waitDone(20);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
